// File: rtl/pc_sequencer.sv
// Program-counter sequencer for picoMIPS: hold, increment, jump, branch and call/return.
// pc, depth and both sticky error flags are all registers, so no input reaches an output combinationally.
module pc_sequencer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int OFFSET_WIDTH = 5,
  parameter int STACK_DEPTH  = 4,
  parameter int FLAG_WIDTH   = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       op,
  input  logic [2:0]                       cond,
  input  logic [FLAG_WIDTH-1:0]            flags,
  input  logic [ADDR_WIDTH-1:0]            target,
  input  logic [OFFSET_WIDTH-1:0]          offset,
  output logic [ADDR_WIDTH-1:0]            pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_overflow,
  output logic                             stack_underflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;

  logic [ADDR_WIDTH-1:0]        r_pc;
  logic [DEPTH_W-1:0]           r_depth;
  logic                         r_ovf;
  logic                         r_unf;
  logic [ADDR_WIDTH-1:0]        r_stack [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0]        w_pc_nxt;
  logic [DEPTH_W-1:0]           w_depth_nxt;
  logic                         w_ovf_nxt;
  logic                         w_unf_nxt;
  logic                         w_push;
  logic                         w_taken;
  logic                         w_full;
  logic [ADDR_WIDTH-1:0]        w_pc_inc;
  logic signed [ADDR_WIDTH-1:0] w_off_ext;
  logic [IDX_W-1:0]             w_push_idx;
  logic [IDX_W-1:0]             w_pop_idx;

  // Flag order is {V,N,Z}: bit 2 = V, bit 1 = N, bit 0 = Z.
  function automatic logic cond_taken(input logic [2:0] c, input logic [FLAG_WIDTH-1:0] f);
    logic t;
    case (c)
      3'd0:    t = 1'b1;
      3'd1:    t = f[0];
      3'd2:    t = ~f[0];
      3'd3:    t = f[1];
      3'd4:    t = ~f[1];
      3'd5:    t = f[2];
      3'd6:    t = ~f[2];
      3'd7:    t = 1'b0;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign w_taken    = cond_taken(cond, flags);
  assign w_pc_inc   = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_off_ext  = ADDR_WIDTH'($signed(offset));
  assign w_full     = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign w_push_idx = IDX_W'(r_depth);
  assign w_pop_idx  = IDX_W'(r_depth - {{(DEPTH_W-1){1'b0}}, 1'b1});

  // Next-state selection for pc, stack depth and sticky flags.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    if (enable) begin
      case (op)
        OP_HOLD:   w_pc_nxt = r_pc;
        OP_INC:    w_pc_nxt = w_pc_inc;
        OP_JUMP:   w_pc_nxt = w_taken ? target : w_pc_inc;
        OP_BRANCH: w_pc_nxt = w_taken ? (r_pc + w_off_ext) : w_pc_inc;
        OP_CALL: begin
          w_pc_nxt = target;
          if (w_full) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_depth_nxt = r_depth + {{(DEPTH_W-1){1'b0}}, 1'b1};
          end
        end
        OP_RET: begin
          if (r_depth != {DEPTH_W{1'b0}}) begin
            w_pc_nxt    = r_stack[w_pop_idx];
            w_depth_nxt = r_depth - {{(DEPTH_W-1){1'b0}}, 1'b1};
          end else begin
            w_pc_nxt  = w_pc_inc;
            w_unf_nxt = 1'b1;
          end
        end
        default:   w_pc_nxt = w_pc_inc;
      endcase
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= {ADDR_WIDTH{1'b0}};
      r_depth <= {DEPTH_W{1'b0}};
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Return-address storage; contents are meaningless above depth so no reset is needed.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign pc              = r_pc;
  assign depth           = r_depth;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the picoMIPS CPU. It is the successor to the increment-only program counter.
- Supports hold, increment, absolute jump, and relative branch.
- Jump and branch can be conditional on the ALU V/N/Z flags.
- Supports subroutine call/return through an internal return-address stack of configurable depth.
- Sits between instruction decode and program memory; drives the instruction fetch address every cycle.

Parameters:
ADDR_WIDTH, 5, program address width; PC wraps modulo 2^ADDR_WIDTH
OFFSET_WIDTH, 5, width of the signed two's-complement relative-branch offset; must be <= ADDR_WIDTH
STACK_DEPTH, 4, number of return-address stack entries; must be >= 1
FLAG_WIDTH, 3, ALU flag count; order {V,N,Z}, flags[2]=V, flags[1]=N, flags[0]=Z

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  advance enable; low = stall, all state held
op  input  3  sequencing operation: 0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6/7 treated as INC
cond  input  3  condition for JUMP/BRANCH: 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 V, 6 !V, 7 never
flags  input  FLAG_WIDTH  ALU flags {V,N,Z}, sampled in the same cycle as op
target  input  ADDR_WIDTH  absolute destination for JUMP/CALL
offset  input  OFFSET_WIDTH  signed offset for BRANCH, relative to the current pc
pc  output  ADDR_WIDTH  current fetch address (registered)
depth  output  $clog2(STACK_DEPTH+1)  number of valid return-stack entries
stack_overflow  output  1  sticky: a CALL was issued with the stack full
stack_underflow  output  1  sticky: a RET was issued with the stack empty

Behaviour:
- Reset (reset=1 at a clock edge):
  - pc=0, depth=0, stack_overflow=0, stack_underflow=0.
  - Stack contents are don't-care.
  - Reset overrides enable and op.
  - Reset mid-sequence discards all pending return addresses.
- enable=0: pc, depth, stack and sticky flags all hold, regardless of op.
- All outputs are registered. Each op issued at edge k takes effect on pc at edge k (single-cycle latency, no pipelining). No combinational path from inputs to outputs.
- Condition: taken = decode(cond, flags), evaluated on the flags present in the same cycle.
- HOLD: pc unchanged.
- INC (and op 6/7): pc <= pc+1 mod 2^ADDR_WIDTH. All-ones wraps to 0.
- JUMP:
  - Taken: pc <= target.
  - Not taken: pc <= pc+1.
- BRANCH:
  - Taken: pc <= pc + sign_extend(offset), truncated to ADDR_WIDTH (wraps in both directions).
  - Not taken: pc <= pc+1.
  - offset=0 with taken = self-loop.
- CALL (unconditional):
  - Stack not full: push (pc+1 mod 2^ADDR_WIDTH) at index depth; depth <= depth+1; pc <= target.
  - Stack full (depth==STACK_DEPTH): no push, depth unchanged, stack_overflow <= 1, pc <= target (jump still taken).
- RET:
  - depth>0: pc <= stack[depth-1]; depth <= depth-1.
  - depth==0: pc <= pc+1, stack_underflow <= 1.
- Stack is LIFO. Entries above depth-1 are never read.
- Sticky flags clear only on reset.
- cond is ignored for HOLD, INC, CALL and RET.

Test Plan:
1. Reset then INC for 33 cycles, ADDR_WIDTH=5 -> pc counts 0..31, then 0 (wrap), then 1. With enable=0 mid-run, pc holds for those cycles.
2. pc=10: BRANCH offset=5'b11101 (-3), cond=0 -> pc=7. pc=30: BRANCH offset=+4, cond=0 -> pc=2 (wrap). BRANCH cond=1 with Z=0 -> pc+1.
3. JUMP target=20 under each cond with flags=3'b101 (V=1, N=0, Z=1) -> taken for cond 0, 1, 4, 5; not taken (pc+1) for cond 2, 3, 6, 7.
4. Nested calls, starting at pc=3:
   - CALL 10 -> pc=10, depth=1; CALL 15 -> pc=15, depth=2.
   - RET -> pc=11, depth=1; RET -> pc=4, depth=0.
5. With STACK_DEPTH=4:
   - Five consecutive CALLs -> depth saturates at 4, stack_overflow=1, pc = fifth target.
   - Four RETs return in LIFO order; a fifth RET -> pc+1, stack_underflow=1, depth=0.
6. Two CALLs, then reset=1 with enable=1 and op=RET -> pc=0, depth=0, flags 0. A following RET sets stack_underflow=1.
